maxpool_unit: RTL and testbench

- Streaming 2x2, stride-2 max-pooling stage directly downstream of the CNN convolution engine.
- Consumes the engine's 6x6 post-ReLU feature map as a row-major word stream and emits the 3x3 pooled map as a row-major stream.
- Valid/ready handshakes on both sides; a start/done pair frames one feature map.

---
 rtl/maxpool_unit.sv | 152 +++++++++++++++
 tb/tb_maxpool_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_unit.sv
// Streaming 2x2 stride-2 signed max-pool over a row-major IN_HEIGHT x IN_WIDTH map.
// Latency: pooled word registered 1 cycle after the accept of its bottom-right pixel.
// Backpressure: in_ready drops while a pooled word is held and out_ready is low.
module maxpool_unit #(
    parameter int IN_WIDTH  = 6,
    parameter int IN_HEIGHT = 6,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int CW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int HW = IN_WIDTH / 2;
    localparam int BW = (HW > 1) ? $clog2(HW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [CW-1:0]             r_col;
    logic [RW-1:0]             r_row;
    logic signed [DATA_W-1:0]  r_pair;
    logic signed [DATA_W-1:0]  r_buf [HW];
    logic [DATA_W-1:0]         r_out;
    logic                      r_out_vld;
    logic                      r_done;

    logic                      w_acc;
    logic                      w_out_hs;
    logic                      w_last_col;
    logic                      w_last_row;
    logic                      w_odd_col;
    logic                      w_odd_row;
    logic                      w_load;
    logic [BW-1:0]             w_bidx;
    logic signed [DATA_W-1:0]  w_px;
    logic signed [DATA_W-1:0]  w_pair_max;
    logic signed [DATA_W-1:0]  w_result;

    assign w_acc      = in_valid & in_ready;
    assign w_out_hs   = r_out_vld & out_ready;
    assign w_last_col = (r_col == CW'(IN_WIDTH - 1));
    assign w_last_row = (r_row == RW'(IN_HEIGHT - 1));
    assign w_odd_col  = r_col[0];
    assign w_odd_row  = r_row[0];
    assign w_bidx     = BW'(r_col >> 1);
    assign w_px       = in_data;
    // Ties fall through to the right-hand operand, which holds the same value.
    assign w_pair_max = (r_pair > w_px) ? r_pair : w_px;
    assign w_result   = (r_buf[w_bidx] > w_pair_max) ? r_buf[w_bidx] : w_pair_max;
    // Bottom-right pixel of a 2x2 window completes one pooled result.
    assign w_load     = w_acc & w_odd_col & w_odd_row;

    assign out_valid = r_out_vld;
    assign out_data  = r_out;
    assign done      = r_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state: the final pixel moves to DRAIN, the final output handshake ends the frame.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_acc && w_last_col && w_last_row) w_next = S_DRAIN;
            S_DRAIN: if (w_out_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; input is only taken when the output slot can move.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_RUN: begin
                in_ready = ~r_out_vld | out_ready;
                busy     = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    // Raster position counters, zeroed when a frame starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Left pixel of each horizontal pair waits here for its partner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_pair <= '0;
        else if (w_acc && !w_odd_col) r_pair <= w_px;
    end

    // Even rows park their pair maxima for the matching odd-row pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HW; i++) r_buf[i] <= '0;
        end else if (w_acc && w_odd_col && !w_odd_row) begin
            r_buf[w_bidx] <= w_pair_max;
        end
    end

    // Output slot: a new result takes priority over clearing on a handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else if (w_load) begin
            r_out     <= w_result;
            r_out_vld <= 1'b1;
        end else if (w_out_hs) begin
            r_out_vld <= 1'b0;
        end
    end

    // Completion pulse, one cycle after the final output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_done <= 1'b0;
        else      r_done <= (r_state == S_DRAIN) && w_out_hs;
    end

endmodule

// File: tb/tb_maxpool_unit.sv
module tb_maxpool_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] pix_q [36];
    logic [31:0] exp_q [9];

    maxpool_unit #(.IN_WIDTH(6), .IN_HEIGHT(6), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 36; i++) pix_q[i] = i;
        exp_q[0] = 7;  exp_q[1] = 9;  exp_q[2] = 11;
        exp_q[3] = 19; exp_q[4] = 21; exp_q[5] = 23;
        exp_q[6] = 31; exp_q[7] = 33; exp_q[8] = 35;
    endtask

    task automatic start_frame();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);
    endtask

    // mode 0: out_ready=1, mode 1: out_ready pattern 1,0,0, mode 2: out_ready=1 plus a stray start pulse
    task automatic run_frame(input int mode);
        int          idx;
        int          nout;
        int          cyc;
        logic        acc;
        logic        pstall;
        logic [31:0] pdat;
        idx = 0; nout = 0; cyc = 0; pstall = 1'b0; pdat = '0;
        while (nout < 9 && cyc < 500) begin
            @(negedge clk);
            in_valid  = (idx < 36);
            in_data   = (idx < 36) ? pix_q[idx] : 32'h0;
            out_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            start     = (mode == 2 && cyc == 10);
            #1;
            if (mode != 1 && idx < 36) chk("in_ready_high", in_ready, 1);
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            if (pstall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pdat);
            end
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("out%0d", nout), out_data, exp_q[nout]);
                nout++;
            end
            pstall = out_valid & ~out_ready;
            pdat   = out_data;
            if (acc) idx++;
            cyc++;
        end
        chk("frame_out_count", nout, 9);
        chk("frame_in_count", idx, 36);
        @(negedge clk);
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("no_extra_out", out_valid, 0);
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int idx;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        // Ramp, free-flowing output
        load_ramp();
        start_frame();
        run_frame(0);

        // Ramp, output stalls 1,0,0
        start_frame();
        run_frame(1);

        // Signed windows
        for (int i = 0; i < 36; i++) pix_q[i] = 32'h0;
        pix_q[0] = -5;  pix_q[1] = -2;  pix_q[6] = -7;  pix_q[7] = -1;
        pix_q[2] = -3;  pix_q[3] = 4;   pix_q[8] = 4;   pix_q[9] = -9;
        pix_q[4] = 32'h7FFFFFFF; pix_q[5] = 32'h7FFFFFFF;
        pix_q[10] = 32'h7FFFFFFF; pix_q[11] = 32'h7FFFFFFF;
        pix_q[12] = -8; pix_q[13] = -8; pix_q[18] = -8; pix_q[19] = -8;
        exp_q[0] = -1; exp_q[1] = 4; exp_q[2] = 32'h7FFFFFFF; exp_q[3] = -8;
        for (int i = 4; i < 9; i++) exp_q[i] = 32'h0;
        start_frame();
        run_frame(1);

        // Reset after 20 pixels
        load_ramp();
        start_frame();
        idx = 0;
        for (int c = 0; c < 60 && idx < 20; c++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = idx;
            out_ready = 1'b1;
            #1;
            if (in_ready) idx++;
        end
        chk("pre_reset_pixels", idx, 20);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_done", done, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("arst_no_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        start_frame();
        run_frame(0);

        // in_valid in IDLE ignored, stray start in RUN ignored
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h55;
            #1;
            chk("idle_ignore_ready", in_ready, 0);
            chk("idle_ignore_busy", busy, 0);
        end
        start_frame();
        run_frame(2);

        // Back-to-back: descending frame started the cycle after done
        for (int i = 0; i < 36; i++) pix_q[i] = 35 - i;
        exp_q[0] = 35; exp_q[1] = 33; exp_q[2] = 31;
        exp_q[3] = 23; exp_q[4] = 21; exp_q[5] = 19;
        exp_q[6] = 11; exp_q[7] = 9;  exp_q[8] = 7;
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("b2b_busy", busy, 1);
        run_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
